uop_dispatch: RTL and testbench

//  Read-side consumer of the uop queue. Requests batches of up to UOP::OUT_UOP uops via get_uop,

---
 rtl/uop_dispatch.sv | 139 +++++++++++++
 tb/tb_uop_dispatch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uop_dispatch.sv
// Read-side uop queue consumer: fetches batches of up to FETCH_W uops and issues one uop per cycle.
// Latency: get_uop in T -> response captured at end of T+1 -> issue_valid earliest in T+2.
// Backpressure: issue_ready stalls the head uop; fetch waits for FETCH_W free slots. Optional counters: UOP_DISPATCH_STATS_EN.
`timescale 1ns/1ps

package UOP;
  localparam int OUT_UOP     = 4;
  localparam int QUEUE_DEPTH = 16;

  typedef logic [$clog2(QUEUE_DEPTH+1)-1:0] uop_size_t;

  typedef struct packed {
    logic [7:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [8:0] imm;
  } uop_ins_t;
endpackage

module uop_dispatch #(
  parameter int FETCH_W   = UOP::OUT_UOP,
  parameter int BUF_DEPTH = 2*UOP::OUT_UOP
) (
  input  logic                           clk,
  input  logic                           reset,
  input  UOP::uop_size_t                 q_elements,
  output logic                           get_uop,
  input  UOP::uop_ins_t                  out_uop [0:FETCH_W-1],
  input  UOP::uop_size_t                 out_size,
  input  logic                           flush,
  output UOP::uop_ins_t                  issue_uop,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
`ifdef UOP_DISPATCH_STATS_EN
  ,
  output logic [31:0]                    stat_issued,
  output logic [31:0]                    stat_starve
`endif
);

  localparam int          CNT_W   = $clog2(BUF_DEPTH+1);
  localparam int          PTR_W   = $clog2(BUF_DEPTH);
  localparam logic [31:0] FETCH_U = 32'(FETCH_W);

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state;
  logic             discard;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  UOP::uop_ins_t    fifo [BUF_DEPTH];

  logic [CNT_W-1:0] free;
  logic [CNT_W-1:0] take;
  logic [CNT_W-1:0] cap_n;
  logic [31:0]      size_w;
  logic [31:0]      free_w;
  logic [31:0]      take_w;
  logic             capture;
  logic             pop;

  // free is measured before this cycle's pop, so a full batch always fits
  assign free        = CNT_W'(BUF_DEPTH) - buf_count;
  assign issue_valid = (buf_count != '0);
  assign issue_uop   = fifo[head];
  assign pop         = issue_valid && issue_ready && !flush;
  assign capture     = (state == RESP) && !discard && !flush;
  assign get_uop     = (state == IDLE) && !reset && !flush &&
                       (q_elements != '0) && (free >= CNT_W'(FETCH_W));

  // Illegal oversized responses are clamped to what fits in the FIFO
  always_comb begin
    size_w = 32'(out_size);
    free_w = 32'(free);
    take_w = (size_w < FETCH_U) ? size_w : FETCH_U;
    if (free_w < take_w) take_w = free_w;
  end

  assign take  = CNT_W'(take_w);
  assign cap_n = capture ? take : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      discard   <= 1'b0;
      head      <= '0;
      tail      <= '0;
      buf_count <= '0;
    end else if (flush) begin
      state     <= IDLE;
      discard   <= (state == IDLE);
      head      <= '0;
      tail      <= '0;
      buf_count <= '0;
    end else begin
      case (state)
        IDLE:    state <= get_uop ? RESP : IDLE;
        default: state <= IDLE;
      endcase
      // A flush seen in the launch cycle poisons the response that follows
      discard   <= 1'b0;
      head      <= head + PTR_W'(pop);
      tail      <= tail + PTR_W'(cap_n);
      buf_count <= buf_count + cap_n - CNT_W'(pop);
    end
  end

  // Batch entries land in order starting at tail; pointer wrap is natural
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (capture && !reset && (32'(i) < take_w)) begin
        fifo[tail + PTR_W'(i)] <= out_uop[i];
      end
    end
  end

`ifdef UOP_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued <= '0;
      stat_starve <= '0;
    end else begin
      if (pop && (stat_issued != '1)) stat_issued <= stat_issued + 32'd1;
      if (!issue_valid && !flush && (stat_starve != '1)) stat_starve <= stat_starve + 32'd1;
    end
  end
`endif

  a_resp_size: assert property (@(posedge clk) disable iff (reset)
    (state == RESP && !discard && !flush) |-> (size_w <= FETCH_U && size_w <= free_w))
    else $error("uop_dispatch: out_size exceeds fetch width or free space");

  a_issue_stable: assert property (@(posedge clk) disable iff (reset)
    (issue_valid && !issue_ready && !flush) |=> (issue_valid && $stable(issue_uop)))
    else $error("uop_dispatch: issue_uop changed while stalled");

endmodule

// File: tb/tb_uop_dispatch.sv
// Scoreboarded bench for uop_dispatch with a behavioural uop-queue model.
`timescale 1ns/1ps

module tb_uop_dispatch;
  import UOP::*;

  localparam int FW = OUT_UOP;
  localparam int BD = 2*OUT_UOP;
  localparam int CW = $clog2(BD+1);

  logic          clk = 1'b0;
  logic          reset;
  uop_size_t     q_elements;
  logic          get_uop;
  uop_ins_t      out_uop [0:FW-1];
  uop_size_t     out_size;
  logic          flush;
  uop_ins_t      issue_uop;
  logic          issue_valid;
  logic          issue_ready;
  logic [CW-1:0] buf_count;
`ifdef UOP_DISPATCH_STATS_EN
  logic [31:0]   stat_issued;
  logic [31:0]   stat_starve;
`endif

  uop_dispatch dut (
    .clk         (clk),
    .reset       (reset),
    .q_elements  (q_elements),
    .get_uop     (get_uop),
    .out_uop     (out_uop),
    .out_size    (out_size),
    .flush       (flush),
    .issue_uop   (issue_uop),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .buf_count   (buf_count)
`ifdef UOP_DISPATCH_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_starve (stat_starve)
`endif
  );

  always #5 clk = ~clk;

  uop_ins_t src [$];
  uop_ins_t exp_q [$];
  int       n_cmp = 0;
  int       n_err = 0;
  logic     req_seen = 1'b0;
  logic     reset_v = 1'b1;
  logic     flush_v = 1'b0;
  logic     ready_v = 1'b0;
  int       next_id = 1;

  function automatic uop_ins_t mk(input int id);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(id);
    return uop_ins_t'(w);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_src(input int n);
    for (int i = 0; i < n; i++) begin
      src.push_back(mk(next_id));
      next_id++;
    end
  endtask

  // Queue model: answers a request seen last cycle; expectations follow what the DUT should keep
  task automatic tick();
    int n;
    @(posedge clk);
    #1;
    reset       = reset_v;
    flush       = flush_v;
    issue_ready = ready_v;
    if (req_seen) begin
      n = (src.size() < FW) ? src.size() : FW;
      out_size = uop_size_t'(n);
      for (int i = 0; i < n; i++) begin
        out_uop[i] = src.pop_front();
        if (!flush_v && !reset_v) exp_q.push_back(out_uop[i]);
      end
    end
    if (flush_v || reset_v) exp_q.delete();
    q_elements = uop_size_t'(src.size());
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    int budget;
    budget  = 300;
    ready_v = 1'b1;
    do begin
      tick();
      budget--;
    end while (budget > 0 &&
               !(src.size() == 0 && exp_q.size() == 0 && buf_count == '0 && !req_seen));
    if (budget == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: buf_count=%0d pending=%0d expected drained", name, buf_count, exp_q.size());
    end else begin
      check({name, "_empty"}, 32'(issue_valid), 32'd0);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      req_seen = get_uop;
    end
  end

  // Monitor: every accepted uop must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && issue_valid && issue_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL issue_unexpected: got %0h expected no uop", issue_uop);
        end else begin
          check("issue_order", 32'(issue_uop), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    issue_ready = 1'b0;
    q_elements  = '0;
    out_size    = '0;
    for (int i = 0; i < FW; i++) out_uop[i] = '0;

    // Reset state
    tick();
    tick();
    at_neg();
    check("rst_get_uop", 32'(get_uop), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_buf_count", 32'(buf_count), 32'd0);
    reset_v = 1'b0;

    // Empty queue: no requests, nothing to issue
    for (int c = 0; c < 10; c++) begin
      tick();
      at_neg();
      check("idle_get_uop", 32'(get_uop), 32'd0);
      check("idle_issue_valid", 32'(issue_valid), 32'd0);
      check("idle_buf_count", 32'(buf_count), 32'd0);
    end

    // Batch of three, issued back to back at T+2..T+4
    ready_v = 1'b1;
    push_src(3);
    tick(); at_neg();
    check("t2_req", 32'(get_uop), 32'd1);
    tick(); at_neg();
    check("t2_resp_get", 32'(get_uop), 32'd0);
    check("t2_resp_valid", 32'(issue_valid), 32'd0);
    tick(); at_neg();
    check("t2_first_valid", 32'(issue_valid), 32'd1);
    check("t2_cnt3", 32'(buf_count), 32'd3);
    tick(); at_neg();
    check("t2_cnt2", 32'(buf_count), 32'd2);
    tick(); at_neg();
    check("t2_cnt1", 32'(buf_count), 32'd1);
    tick(); at_neg();
    check("t2_cnt0", 32'(buf_count), 32'd0);
    check("t2_done_valid", 32'(issue_valid), 32'd0);

    // Fill to capacity with backend stalled
    ready_v = 1'b0;
    push_src(12);
    tick(); at_neg();
    check("t3_req1", 32'(get_uop), 32'd1);
    tick(); at_neg();
    check("t3_resp1_get", 32'(get_uop), 32'd0);
    tick(); at_neg();
    check("t3_cnt4", 32'(buf_count), 32'd4);
    check("t3_req2", 32'(get_uop), 32'd1);
    tick();
    for (int c = 0; c < 3; c++) begin
      tick(); at_neg();
      check("t3_full_cnt", 32'(buf_count), 32'd8);
      check("t3_full_hold", 32'(get_uop), 32'd0);
      check("t3_full_valid", 32'(issue_valid), 32'd1);
    end
    drain("t3");

    // Flush during a response drops both buffered and in-flight uops
    ready_v = 1'b0;
    push_src(2);
    tick(); tick(); tick(); at_neg();
    check("t5_pre_cnt", 32'(buf_count), 32'd2);
    push_src(4);
    tick(); at_neg();
    check("t5_req", 32'(get_uop), 32'd1);
    flush_v = 1'b1;
    tick();
    flush_v = 1'b0;
    tick(); at_neg();
    check("t5_flush_cnt", 32'(buf_count), 32'd0);
    check("t5_flush_valid", 32'(issue_valid), 32'd0);
    ready_v = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(); at_neg();
      check("t5_no_issue", 32'(issue_valid), 32'd0);
    end

    // Advance pointers to 6, then a batch of four spans the wrap
    push_src(6);
    drain("t4_pre");
    ready_v = 1'b0;
    push_src(4);
    tick(); at_neg();
    check("t4_req", 32'(get_uop), 32'd1);
    tick();
    tick(); at_neg();
    check("t4_cnt4", 32'(buf_count), 32'd4);
    drain("t4");

    // Capture of two alongside a pop with three buffered
    ready_v = 1'b0;
    push_src(3);
    tick(); tick(); tick(); at_neg();
    check("t6_cnt3", 32'(buf_count), 32'd3);
    push_src(2);
    tick(); at_neg();
    check("t6_req", 32'(get_uop), 32'd1);
    ready_v = 1'b1;
    tick();
    ready_v = 1'b0;
    tick(); at_neg();
    check("t6_cnt4", 32'(buf_count), 32'd4);
    drain("t6");

    // Reset during the response cycle drops the response
    ready_v = 1'b0;
    push_src(2);
    tick(); at_neg();
    check("rr_req", 32'(get_uop), 32'd1);
    reset_v = 1'b1;
    tick();
    reset_v = 1'b0;
    tick(); at_neg();
    check("rr_cnt", 32'(buf_count), 32'd0);
    check("rr_valid", 32'(issue_valid), 32'd0);
    tick(); at_neg();
    check("rr_no_req", 32'(get_uop), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
